// File: rtl/sfr_bank.sv
// Special-function register bank: SREG, SP and six general SFRs with ALU flag
// merge, stack push/pop adjustment, sticky SP wrap flags and a write-through read port.
module sfr_bank #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 3,
   parameter logic [DATA_WIDTH-1:0] SP_RESET   = 8'hFF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] flag_we,
   input  logic [DATA_WIDTH-1:0] flag_in,
   input  logic                  sp_push,
   input  logic                  sp_pop,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] sreg_out,
   output logic [DATA_WIDTH-1:0] sp_out,
   output logic                  sp_ovf,
   output logic                  sp_unf,
   input  logic                  err_clear
);

   localparam int                    NUM_REGS  = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ADDR_SREG = '0;
   localparam logic [ADDR_WIDTH-1:0] ADDR_SP   = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] bank_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] bank_d [NUM_REGS];
   logic                  ovf_set;
   logic                  unf_set;
   logic                  wr_sreg;
   logic                  wr_sp;

   assign wr_sreg = wr_en && (wr_addr == ADDR_SREG);
   assign wr_sp   = wr_en && (wr_addr == ADDR_SP);

   always_comb begin
      bank_d  = bank_q;
      ovf_set = 1'b0;
      unf_set = 1'b0;

      for (int i = 2; i < NUM_REGS; i++) begin
         if (wr_en && (wr_addr == ADDR_WIDTH'(i)))
            bank_d[i] = wr_data;
      end

      // explicit write replaces the whole SREG, masking out any ALU flag update
      if (wr_sreg)
         bank_d[0] = wr_data;
      else
         bank_d[0] = (bank_q[0] & ~flag_we) | (flag_in & flag_we);

      if (wr_sp) begin
         bank_d[1] = wr_data;
      end else if (sp_push && !sp_pop) begin
         bank_d[1] = bank_q[1] - DATA_WIDTH'(1);
         ovf_set   = (bank_q[1] == '0);
      end else if (sp_pop && !sp_push) begin
         bank_d[1] = bank_q[1] + DATA_WIDTH'(1);
         unf_set   = (bank_q[1] == '1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            bank_q[i] <= (i == 1) ? SP_RESET : '0;
         rd_data <= '0;
         sp_ovf  <= 1'b0;
         sp_unf  <= 1'b0;
      end else begin
         bank_q  <= bank_d;
         rd_data <= bank_d[rd_addr];
         // a wrap in the same cycle as err_clear keeps the flag set
         sp_ovf  <= ovf_set | (sp_ovf & ~err_clear);
         sp_unf  <= unf_set | (sp_unf & ~err_clear);
      end
   end

   assign sreg_out = bank_q[0];
   assign sp_out   = bank_q[1];

endmodule

// File: doc/sfr_bank.md
Name: sfr_bank

Overview:
Special-function register bank for the Banff Execute stage. Sits directly downstream of sfr_input_sel_mux and consumes that mux's selected write data and address. It holds the status register (SREG), the stack pointer (SP) and six general SFRs. It also applies ALU flag updates and stack push/pop adjustments, and provides a registered read port back to the Execute datapath.

Parameters:
DATA_WIDTH, 8, width of every SFR.
ADDR_WIDTH, 3, SFR address width; bank size is 2**ADDR_WIDTH (8).
SP_RESET, 8'hFF, reset value of SP.

Ports:
clock  input  1  core clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state to reset values
wr_en  input  1  explicit SFR write strobe from sfr_input_sel_mux
wr_addr  input  ADDR_WIDTH  explicit write address
wr_data  input  DATA_WIDTH  explicit write data (mux output)
flag_we  input  DATA_WIDTH  per-bit SREG update mask from the ALU
flag_in  input  DATA_WIDTH  new SREG flag values from the ALU
sp_push  input  1  decrement SP by 1
sp_pop  input  1  increment SP by 1
rd_addr  input  ADDR_WIDTH  read address
rd_data  output  DATA_WIDTH  registered read data
sreg_out  output  DATA_WIDTH  current SREG value (register output)
sp_out  output  DATA_WIDTH  current SP value (register output)
sp_ovf  output  1  sticky flag: push wrapped SP from 0x00 to 0xFF
sp_unf  output  1  sticky flag: pop wrapped SP from 0xFF to 0x00
err_clear  input  1  clears sp_ovf and sp_unf

Behaviour:
- Address map: 0 = SREG, 1 = SP, 2..7 = GP SFRs (no side effects).
- Reset values (asynchronous, immediate on reset assertion):
  - SREG = 0; SP = SP_RESET; GP SFRs = 0.
  - rd_data = 0; sp_ovf = 0; sp_unf = 0.
- SREG next-state, per bit i:
  - wr_en && wr_addr == 0: SREG[i] = wr_data[i]. An explicit write overrides all flag updates in the same cycle.
  - else if flag_we[i]: SREG[i] = flag_in[i].
  - else: hold.
- SP next-state, highest priority first:
  - wr_en && wr_addr == 1: SP = wr_data. Push/pop are ignored and no wrap flags are set.
  - sp_push && sp_pop together: SP holds, no flags.
  - sp_push alone: SP = SP - 1, modulo 2**DATA_WIDTH. If SP was 0x00, set sp_ovf.
  - sp_pop alone: SP = SP + 1, modulo 2**DATA_WIDTH. If SP was 0xFF, set sp_unf.
- GP SFRs: written on wr_en with the matching address; otherwise hold.
- Sticky error flags:
  - err_clear clears both flags.
  - If a wrap event occurs in the same cycle as err_clear, the set wins (flag = 1).
- Read port:
  - One-cycle latency: rd_data is loaded at edge N with the next-state value of register rd_addr, so all cycle-N updates are included (write-through).
  - A read issued the same cycle as a write to the same address returns the new value.
- sreg_out and sp_out are driven directly from the registers (zero-latency view of the current state).
- Reset asserted mid-operation:
  - All state returns to reset values immediately; in-flight writes and pending reads are discarded.
  - After deassertion, the first rising edge behaves as a normal cycle.
- No handshake and no stall: every input is sampled on every edge.

Test Plan:
- Reset: assert reset asynchronously between edges → SREG = 0x00, SP = 0xFF, rd_data = 0x00, sp_ovf = 0, sp_unf = 0 without waiting for a clock edge.
- Flag masking: SREG = 0xA5; flag_we = 0x0F, flag_in = 0x03 → SREG = 0xA3 next cycle. Same cycle plus wr_en to addr 0 with 0x3C → SREG = 0x3C.
- SP wrap: write SP = 0x00, then sp_push → SP = 0xFF, sp_ovf = 1. Next, sp_pop → SP = 0x00, sp_unf = 1. Then err_clear → both flags 0.
- SP priority: SP = 0x10 with push + pop together → SP = 0x10. SP = 0x10 with push + wr_en addr 1 data 0x80 → SP = 0x80, no flag set.
- Read bypass: rd_addr = 5 with wr_en addr 5 data 0x5A in the same cycle → rd_data = 0x5A one cycle later. Read of addr 1 one cycle after a push from 0x20 → rd_data = 0x1F.
- Clear vs set: SP = 0x00, sp_push and err_clear together → sp_ovf = 1, SP = 0xFF.
